mor1kx_rf_ram_mp_sclk: RTL

Single-clock register-file RAM with a parametrised number of registered read ports, per-port write-to-read bypass, a hardware clear sequencer, and a parametrised set of monitored ("tap") addresses. Each tap holds a shadow copy of the last value written to its address. It replaces the fixed two-tap, single-read-port RF RAM under the mor1kx register file. The taps feed the shadow-stack/CSAW monitor, and the extra read ports serve the multi-operand decode path.

---
 rtl/mor1kx_rf_ram_mp_sclk.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mor1kx_rf_ram_mp_sclk.sv
// Multi-read-port register-file RAM with write bypass, clear sweep
// and shadowed tap addresses for the mor1kx register file.
module mor1kx_rf_ram_mp_sclk #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_RPORTS     = 2,
    parameter int ENABLE_BYPASS  = 1,
    parameter int NUM_TAPS       = 2,
    parameter logic [NUM_TAPS*ADDR_WIDTH-1:0] TAP_ADDRS = {5'd20, 5'd9},
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr,
    input  logic [NUM_RPORTS-1:0]            re,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic                             we,
    input  logic [DATA_WIDTH-1:0]            din,
    input  logic                             clr,
    output logic                             busy,
    output logic [NUM_RPORTS*DATA_WIDTH-1:0] dout,
    output logic [NUM_TAPS*DATA_WIDTH-1:0]   tap_data,
    output logic [NUM_TAPS-1:0]              tap_valid,
    output logic [NUM_TAPS-1:0]              tap_upd
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {INIT, RUN} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_wa;
    logic [DATA_WIDTH-1:0]   mem_wd;
    logic                    run;

    if (NUM_RPORTS < 1 || NUM_TAPS < 1) begin : g_bad_cfg
        $error("NUM_RPORTS and NUM_TAPS must be at least 1");
    end

    assign run  = (state == RUN);
    assign busy = (state == INIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
            cnt   <= '0;
        end else begin
            unique case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state <= RUN;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (clr) begin
                        state <= INIT;
                        cnt   <= '0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // The sweep owns the single write port while busy.
    always_comb begin
        mem_we = busy | we;
        mem_wa = busy ? cnt : waddr;
        mem_wd = busy ? '0 : din;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wa] <= mem_wd;
    end

    for (genvar i = 0; i < NUM_RPORTS; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rdata;
        logic [DATA_WIDTH-1:0] din_r;
        logic                  byp;
        logic                  hit;

        assign ra  = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign hit = (ENABLE_BYPASS != 0) && we && (waddr == ra);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata <= '0;
                din_r <= '0;
                byp   <= 1'b0;
            end else if (run && re[i]) begin
                rdata <= mem[ra];
                byp   <= hit;
                if (hit) din_r <= din;
            end
        end

        assign dout[i*DATA_WIDTH +: DATA_WIDTH] = byp ? din_r : rdata;
    end

    for (genvar i = 0; i < NUM_TAPS; i++) begin : g_tap
        localparam logic [ADDR_WIDTH-1:0] TA =
            TAP_ADDRS[i*ADDR_WIDTH +: ADDR_WIDTH];

        logic [DATA_WIDTH-1:0] data;
        logic                  valid;
        logic                  upd;
        logic                  hit;

        if (int'(TA) >= DEPTH) begin : g_bad_tap
            $error("tap address out of range");
        end

        assign hit = we && (waddr == TA);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data  <= '0;
                valid <= 1'b0;
                upd   <= 1'b0;
            end else if (busy) begin
                upd <= 1'b0;
                if (cnt == TA) begin
                    data  <= '0;
                    valid <= 1'b0;
                end
            end else begin
                upd <= hit;
                if (hit) begin
                    data  <= din;
                    valid <= 1'b1;
                end
            end
        end

        assign tap_data[i*DATA_WIDTH +: DATA_WIDTH] = data;
        assign tap_valid[i] = valid;
        assign tap_upd[i]   = upd;
    end

endmodule
